// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
//
// Transmit side of the bulk UART link. Bulk words ({address, 32-bit data})
// arrive on a valid/ready write port and are buffered in a small FIFO. Each
// buffered entry is sent on uart_txd as one frame of five 9-bit UART words:
//   W0 = {1'b1, addr zero-extended to 8 bits}
//   W1 = {1'b0, data[31:24]}, W2 = {1'b0, data[23:16]},
//   W3 = {1'b0, data[15:8]},  W4 = {1'b0, data[7:0]}
// Every word goes out as start bit (0), bits [0]..[8] LSB first, stop bit (1).
// Each bit lasts PULSE_WIDTH = CLK_FREQ / UART_BAUD_RATE clk cycles.
// Consecutive words and consecutive frames follow each other with no gap.
//
// Ports:
//   clk           in   system clock, rising edge
//   rstn          in   asynchronous active-low reset (flushes FIFO, aborts frame)
//   bulk_tx_valid in   write request
//   bulk_tx_ready out  FIFO can accept (not full)
//   bulk_tx_addr  in   destination address, ADDR_WIDTH bits
//   bulk_tx_data  in   payload, DATA_WIDTH bits
//   uart_txd      out  serial line, idle high, registered
//   tx_busy       out  frame on the line or entries still buffered
// -----------------------------------------------------------------------------
module uart_tx_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int RAM_DEPTH       = 256,
    parameter int BULK_FIFO_DEPTH = 4,
    parameter int UART_BAUD_RATE  = 115200,
    parameter int CLK_FREQ        = 100_000_000,
    localparam int ADDR_WIDTH     = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  bulk_tx_valid,
    output logic                  bulk_tx_ready,
    input  logic [ADDR_WIDTH-1:0] bulk_tx_addr,
    input  logic [DATA_WIDTH-1:0] bulk_tx_data,
    output logic                  uart_txd,
    output logic                  tx_busy
);

    localparam int PULSE_WIDTH = CLK_FREQ / UART_BAUD_RATE;
    localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IDX_W       = $clog2(BULK_FIFO_DEPTH);
    localparam int PTR_W       = IDX_W + 1;
    localparam int ENTRY_W     = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Select word idx of the frame built from an 8-bit address and 32-bit data.
    function automatic logic [8:0] frame_word(input logic [2:0]  idx,
                                              input logic [7:0]  addr8,
                                              input logic [31:0] data);
        logic [8:0] w;
        case (idx)
            3'd0:    w = {1'b1, addr8};
            3'd1:    w = {1'b0, data[31:24]};
            3'd2:    w = {1'b0, data[23:16]};
            3'd3:    w = {1'b0, data[15:8]};
            3'd4:    w = {1'b0, data[7:0]};
            default: w = {1'b1, 8'hff};
        endcase
        return w;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0]    fifo_mem_r [BULK_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [7:0]            head_addr8_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = bulk_tx_valid && !full_s;
    assign head_s  = fifo_mem_r[rd_ptr_r[IDX_W-1:0]];
    assign head_data_s = head_s[DATA_WIDTH-1:0];

    // Zero-extend the head address to the 8-bit header payload.
    always_comb begin
        head_addr8_s = 8'h00;
        head_addr8_s[ADDR_WIDTH-1:0] = head_s[ENTRY_W-1 -: ADDR_WIDTH];
    end

    // FIFO storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[IDX_W-1:0]] <= {bulk_tx_addr, bulk_tx_data};
        end
    end

    // FIFO pointers; push and pop in the same cycle both advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // ----------------------------------------------------------- Serializer
    logic [1:0]       state_r,    state_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [3:0]       bit_idx_r,  bit_idx_s;
    logic [2:0]       word_idx_r, word_idx_s;
    logic [8:0]       word_r,     word_s;
    logic [7:0]       cur_addr8_r, cur_addr8_s;
    logic [31:0]      cur_data_r,  cur_data_s;
    logic             txd_r,      txd_s;
    logic             baud_done_s;

    assign baud_done_s = (baud_cnt_r == PW_LAST);

    // Next-state logic: bit timing, word sequencing and FIFO pops.
    always_comb begin
        state_s     = state_r;
        baud_cnt_s  = baud_cnt_r + CNT_W'(1);
        bit_idx_s   = bit_idx_r;
        word_idx_s  = word_idx_r;
        word_s      = word_r;
        cur_addr8_s = cur_addr8_r;
        cur_data_s  = cur_data_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_cnt_s = {CNT_W{1'b0}};
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_s     = ST_START;
                    word_idx_s  = 3'd0;
                    cur_addr8_s = head_addr8_s;
                    cur_data_s  = head_data_s;
                    word_s      = frame_word(3'd0, head_addr8_s, head_data_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    state_s    = ST_DATA;
                    baud_cnt_s = {CNT_W{1'b0}};
                    bit_idx_s  = 4'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_cnt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == 4'd8) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 4'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_cnt_s = {CNT_W{1'b0}};
                    if (word_idx_r != 3'd4) begin
                        // Next word of the same frame follows immediately.
                        state_s    = ST_START;
                        word_idx_s = word_idx_r + 3'd1;
                        word_s     = frame_word(word_idx_r + 3'd1, cur_addr8_r, cur_data_r);
                    end else if (!empty_s) begin
                        // Next frame starts without returning to IDLE.
                        pop_s       = 1'b1;
                        state_s     = ST_START;
                        word_idx_s  = 3'd0;
                        cur_addr8_s = head_addr8_s;
                        cur_data_s  = head_data_s;
                        word_s      = frame_word(3'd0, head_addr8_s, head_data_s);
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Line level for the current state; registered below, so the pin lags the FSM by one cycle.
    always_comb begin
        txd_s = 1'b1;
        case (state_r)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = word_r[bit_idx_r];
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // Serializer state registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= {CNT_W{1'b0}};
            bit_idx_r   <= 4'd0;
            word_idx_r  <= 3'd0;
            word_r      <= 9'h000;
            cur_addr8_r <= 8'h00;
            cur_data_r  <= 32'h0000_0000;
            txd_r       <= 1'b1;
        end else begin
            state_r     <= state_s;
            baud_cnt_r  <= baud_cnt_s;
            bit_idx_r   <= bit_idx_s;
            word_idx_r  <= word_idx_s;
            word_r      <= word_s;
            cur_addr8_r <= cur_addr8_s;
            cur_data_r  <= cur_data_s;
            txd_r       <= txd_s;
        end
    end

    assign uart_txd      = txd_r;
    assign bulk_tx_ready = !full_s;
    assign tx_busy       = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for uart_tx_controller. Runs with a short bit period
// (PULSE_WIDTH = 8) so that multi-frame scenarios stay short. The serial line
// is decoded by sampling mid-bit and compared with hand-computed words.
// -----------------------------------------------------------------------------
module tb_uart_tx_controller;

    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bulk_tx_valid;
    logic        bulk_tx_ready;
    logic [7:0]  bulk_tx_addr;
    logic [31:0] bulk_tx_data;
    logic        uart_txd;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned pcyc = 0;

    logic [8:0]  rxw [0:63];
    int unsigned rxt [0:63];

    uart_tx_controller #(
        .DATA_WIDTH      (32),
        .RAM_DEPTH       (256),
        .BULK_FIFO_DEPTH (4),
        .UART_BAUD_RATE  (100),
        .CLK_FREQ        (800)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bulk_tx_valid (bulk_tx_valid),
        .bulk_tx_ready (bulk_tx_ready),
        .bulk_tx_addr  (bulk_tx_addr),
        .bulk_tx_data  (bulk_tx_data),
        .uart_txd      (uart_txd),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used for latency and spacing measurements.
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected 9-bit word i of the frame for one bulk entry.
    function automatic logic [8:0] exp_word(input logic [7:0] a, input logic [31:0] d, input int i);
        case (i)
            0:       return {1'b1, a};
            1:       return {1'b0, d[31:24]};
            2:       return {1'b0, d[23:16]};
            3:       return {1'b0, d[15:8]};
            default: return {1'b0, d[7:0]};
        endcase
    endfunction

    // Called at a negedge; present one entry for exactly one rising edge.
    task automatic push(input logic [7:0] a, input logic [31:0] d);
        bulk_tx_valid = 1'b1;
        bulk_tx_addr  = a;
        bulk_tx_data  = d;
        @(posedge clk);
        @(negedge clk);
        bulk_tx_valid = 1'b0;
    endtask

    // Hold valid until the FIFO accepts; reports how many negedges ready stayed low.
    task automatic push_wait(input logic [7:0] a, input logic [31:0] d, output int waited);
        bulk_tx_valid = 1'b1;
        bulk_tx_addr  = a;
        bulk_tx_data  = d;
        waited = 0;
        while (bulk_tx_ready !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check_eq("push_wait_ready", bulk_tx_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bulk_tx_valid = 1'b0;
    endtask

    // Decode one word from the line; called at a negedge while the line is high (or just fell).
    task automatic rx_word(output logic [8:0] w, output int unsigned t_fall);
        int n;
        n = 0;
        w = 9'h1ff;
        t_fall = 0;
        while (uart_txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (uart_txd !== 1'b0) begin
            check_eq("rx_start_timeout", uart_txd, 1'b0);
            return;
        end
        t_fall = pcyc;
        repeat (PW / 2) @(negedge clk);
        check_eq("rx_start_bit", uart_txd, 1'b0);
        for (int i = 0; i < 9; i++) begin
            repeat (PW) @(negedge clk);
            w[i] = uart_txd;
        end
        repeat (PW) @(negedge clk);
        check_eq("rx_stop_bit", uart_txd, 1'b1);
    endtask

    task automatic rx_many(input int nwords);
        logic [8:0]  w;
        int unsigned t;
        for (int i = 0; i < nwords; i++) begin
            rx_word(w, t);
            rxw[i] = w;
            rxt[i] = t;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_idle", tx_busy, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    logic [7:0]  ta [0:5];
    logic [31:0] td [0:5];

    // Compare 6 decoded frames against ta/td and check gap-free word spacing.
    task automatic check_six_frames(input string tag);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("%s_f%0d_w%0d", tag, f, i), rxw[f*5+i], exp_word(ta[f], td[f], i));
            end
        end
        for (int i = 1; i < 30; i++) begin
            check_eq($sformatf("%s_gap%0d", tag, i), rxt[i] - rxt[i-1], 11 * PW);
        end
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int          bad;
        int          n;
        int          waited;

        rstn          = 1'b0;
        bulk_tx_valid = 1'b0;
        bulk_tx_addr  = 8'h00;
        bulk_tx_data  = 32'h0000_0000;

        // ---------------- reset idle
        repeat (100) @(negedge clk);
        check_eq("rst_txd",   uart_txd,      1'b1);
        check_eq("rst_ready", bulk_tx_ready, 1'b1);
        check_eq("rst_busy",  tx_busy,       1'b0);
        rstn = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || bulk_tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check_eq("idle_1000", bad, 0);

        // ---------------- single frame, latency and length
        push(8'h22, 32'h32ff_ffff);
        check_eq("lat_edge0_txd", uart_txd, 1'b1);
        check_eq("lat_edge0_busy", tx_busy, 1'b1);
        @(negedge clk);
        check_eq("lat_edge1_txd", uart_txd, 1'b1);
        @(negedge clk);
        check_eq("lat_edge2_txd", uart_txd, 1'b0);
        t0 = pcyc;
        rx_many(5);
        check_eq("single_w0", rxw[0], 9'h122);
        check_eq("single_w1", rxw[1], 9'h032);
        check_eq("single_w2", rxw[2], 9'h0ff);
        check_eq("single_w3", rxw[3], 9'h0ff);
        check_eq("single_w4", rxw[4], 9'h0ff);
        for (int i = 1; i < 5; i++) begin
            check_eq($sformatf("single_gap%0d", i), rxt[i] - rxt[i-1], 11 * PW);
        end
        n = 0;
        while (tx_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        t1 = pcyc;
        // Busy drops on the edge the FSM returns to IDLE, one edge before the
        // registered stop bit of W4 completes on the pin.
        check_eq("frame_len", t1 - t0, 55 * PW - 1);
        check_eq("frame_end_txd", uart_txd, 1'b1);
        check_eq("frame_end_ready", bulk_tx_ready, 1'b1);
        repeat (5) @(negedge clk);

        // ---------------- back-to-back, full FIFO, held-off push
        ta[0] = 8'h01; td[0] = 32'h1122_3344;
        ta[1] = 8'h02; td[1] = 32'ha5a5_5a5a;
        ta[2] = 8'h03; td[2] = 32'h0000_0001;
        ta[3] = 8'h04; td[3] = 32'h8000_0000;
        ta[4] = 8'h05; td[4] = 32'hdead_beef;
        ta[5] = 8'h06; td[5] = 32'hcafe_f00d;
        push(ta[0], td[0]);
        fork
            begin
                for (int k = 1; k < 5; k++) push(ta[k], td[k]);
                check_eq("b2b_ready_full", bulk_tx_ready, 1'b0);
                check_eq("b2b_busy", tx_busy, 1'b1);
                push_wait(ta[5], td[5], waited);
                // Entry 0 popped one edge after its push; entry 1 pops 55*PW
                // edges later, three edges after the 5th entry was presented.
                check_eq("b2b_held_cycles", waited, 55 * PW - 3);
            end
            begin
                rx_many(30);
            end
        join
        check_six_frames("b2b");
        wait_idle();

        // ---------------- simultaneous push and pop at 3 entries
        ta[0] = 8'h10; td[0] = 32'h0102_0304;
        ta[1] = 8'h11; td[1] = 32'hf0e1_d2c3;
        ta[2] = 8'h12; td[2] = 32'h5555_aaaa;
        ta[3] = 8'h13; td[3] = 32'h0f0f_f0f0;
        ta[4] = 8'h14; td[4] = 32'h7e00_0081;
        ta[5] = 8'h15; td[5] = 32'h1234_5678;
        push(ta[0], td[0]);
        fork
            begin
                for (int k = 1; k < 4; k++) push(ta[k], td[k]);
                check_eq("sim_ready_at3", bulk_tx_ready, 1'b1);
                // Line up the next push with the edge that pops entry 1.
                repeat (55 * PW - 3) @(negedge clk);
                push(ta[4], td[4]);
                check_eq("sim_ready_after", bulk_tx_ready, 1'b1);
                push(ta[5], td[5]);
                check_eq("sim_full_after", bulk_tx_ready, 1'b0);
            end
            begin
                rx_many(30);
            end
        join
        check_six_frames("sim");
        wait_idle();

        // ---------------- reset during bit 4 of W2, second entry queued
        push(8'h20, 32'hffef_ffff);
        push(8'h21, 32'h1234_5678);
        n = 0;
        while (uart_txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_fall", uart_txd, 1'b0);
        // W2 starts 22 bit slots after the first start bit; data bit 4 is slot 5 of it.
        repeat (27 * PW + PW / 2) @(negedge clk);
        check_eq("mid_pre_rst_txd", uart_txd, 1'b0);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_txd", uart_txd, 1'b1);
        check_eq("mid_rst_busy", tx_busy, 1'b0);
        check_eq("mid_rst_ready", bulk_tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (2 * 55 * PW) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || bulk_tx_ready !== 1'b1) bad++;
        end
        check_eq("post_rst_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
